fpa_operand_gen: RTL and testbench

//  Hardware stimulus transmitter for the single-precision FP adder (top): emits a stream of

---
 rtl/fpa_operand_gen.sv | 155 +++++++++++++++
 tb/tb_fpa_operand_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_operand_gen.sv
// fpa_operand_gen: LFSR-driven IEEE-754 operand-pair transmitter for the FP adder.
// Emits num_pairs (A,B) pairs of the selected class over a valid/ready handshake.
// Optional feature macro: FPA_GEN_ABORT_EN adds an 'abort' input that ends a run early.
`timescale 1ns/1ps
module fpa_operand_gen #(
   parameter logic [31:0] SEED    = 32'hACE1_2468,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         class_a,
   input  logic [2:0]         class_b,
   input  logic [COUNT_W-1:0] num_pairs,
`ifdef FPA_GEN_ABORT_EN
   input  logic               abort,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        number_A,
   output logic [31:0]        number_B,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] pairs_sent
);

   localparam logic [31:0] POLY       = 32'h8020_0003;
   localparam logic [31:0] SEED_A     = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [31:0] SEED_B_RAW = SEED ^ 32'h5A5A_5A5A;
   localparam logic [31:0] SEED_B     = (SEED_B_RAW == 32'h0) ? 32'h1 : SEED_B_RAW;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [31:0]          r_lfsr_a, r_lfsr_b, w_lfsr_a_nxt, w_lfsr_b_nxt;
   logic [2:0]           r_cls_a, r_cls_b, w_cls_a_nxt, w_cls_b_nxt;
   logic [COUNT_W-1:0]   r_num, w_num_nxt, w_cnt_nxt;
   logic [31:0]          w_a_nxt, w_b_nxt, w_step_a, w_step_b;
   logic                 w_valid_nxt, w_xfer, w_last;

   // One Galois right-shift step of a 32-bit LFSR
   function automatic logic [31:0] f_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   // Shape raw LFSR bits into an operand of the requested class
   function automatic logic [31:0] f_operand(input logic [2:0] cls, input logic [31:0] r);
      logic [7:0]  exp;
      logic [22:0] man;
      exp = r[30:23];
      man = r[22:0];
      case (cls)
         3'd0:    f_operand = {r[31], 8'h00, 23'h0};
         3'd1:    f_operand = {r[31], 8'h00, (man == 23'h0) ? 23'h1 : man};
         3'd3:    f_operand = {r[31], 8'hFF, 23'h0};
         3'd4:    f_operand = {r[31], 8'hFF, (man == 23'h0) ? 23'h40_0000 : man};
         3'd7:    f_operand = r;
         default: begin
            if (exp == 8'h00)      exp = 8'h01;
            else if (exp == 8'hFF) exp = 8'hFE;
            f_operand = {r[31], exp, man};
         end
      endcase
   endfunction

   assign w_xfer   = out_valid & out_ready;
   assign w_last   = (pairs_sent == (r_num - COUNT_W'(1)));
   assign w_step_a = f_step(r_lfsr_a);
   assign w_step_b = f_step(r_lfsr_b);

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_valid_nxt  = out_valid;
      w_a_nxt      = number_A;
      w_b_nxt      = number_B;
      w_lfsr_a_nxt = r_lfsr_a;
      w_lfsr_b_nxt = r_lfsr_b;
      w_cls_a_nxt  = r_cls_a;
      w_cls_b_nxt  = r_cls_b;
      w_num_nxt    = r_num;
      w_cnt_nxt    = pairs_sent;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_cls_a_nxt = class_a;
               w_cls_b_nxt = class_b;
               w_num_nxt   = num_pairs;
               w_cnt_nxt   = '0;
               if (num_pairs == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_SEND;
                  w_valid_nxt = 1'b1;
                  w_a_nxt     = f_operand(class_a, r_lfsr_a);
                  w_b_nxt     = f_operand(class_b, r_lfsr_b);
               end
            end
         end
         S_SEND: begin
            if (w_xfer) begin
               w_lfsr_a_nxt = w_step_a;
               w_lfsr_b_nxt = w_step_b;
               w_cnt_nxt    = pairs_sent + COUNT_W'(1);
               w_a_nxt      = f_operand(r_cls_a, w_step_a);
               w_b_nxt      = f_operand(r_cls_b, w_step_b);
               if (w_last) begin
                  w_valid_nxt = 1'b0;
                  w_state_nxt = S_DONE;
               end
            end
`ifdef FPA_GEN_ABORT_EN
            if (abort) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end
`endif
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_lfsr_a   <= SEED_A;
         r_lfsr_b   <= SEED_B;
         r_cls_a    <= 3'd0;
         r_cls_b    <= 3'd0;
         r_num      <= '0;
         pairs_sent <= '0;
         out_valid  <= 1'b0;
         number_A   <= 32'h0;
         number_B   <= 32'h0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lfsr_a   <= w_lfsr_a_nxt;
         r_lfsr_b   <= w_lfsr_b_nxt;
         r_cls_a    <= w_cls_a_nxt;
         r_cls_b    <= w_cls_b_nxt;
         r_num      <= w_num_nxt;
         pairs_sent <= w_cnt_nxt;
         out_valid  <= w_valid_nxt;
         number_A   <= w_a_nxt;
         number_B   <= w_b_nxt;
         busy       <= (w_state_nxt != S_IDLE);
         done       <= (w_state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_fpa_operand_gen.sv
// Self-checking bench for fpa_operand_gen: behavioural model + per-cycle compare.
`timescale 1ns/1ps
module tb_fpa_operand_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  class_a, class_b;
   logic [15:0] num_pairs;
   logic        abort;
   logic        out_valid, out_ready;
   logic [31:0] number_A, number_B;
   logic        busy, done;
   logic [15:0] pairs_sent;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];

   // model state
   logic        e_valid, e_busy, e_done;
   logic [31:0] e_A, e_B, m_la, m_lb;
   int          e_sent, m_num, m_ca, m_cb;

   fpa_operand_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .class_a   (class_a),
      .class_b   (class_b),
      .num_pairs (num_pairs),
`ifdef FPA_GEN_ABORT_EN
      .abort     (abort),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .number_A  (number_A),
      .number_B  (number_B),
      .busy      (busy),
      .done      (done),
      .pairs_sent(pairs_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_step(input logic [31:0] r);
      return (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] m_operand(input int cls, input logic [31:0] r);
      logic        s = r[31];
      logic [7:0]  e = r[30:23];
      logic [22:0] m = r[22:0];
      if (cls == 0) return {s, 31'h0};
      if (cls == 1) return {s, 8'h00, (m == 23'h0) ? 23'h1 : m};
      if (cls == 3) return {s, 8'hFF, 23'h0};
      if (cls == 4) return {s, 8'hFF, (m == 23'h0) ? 23'h40_0000 : m};
      if (cls == 7) return r;
      if (e == 8'h00) e = 8'h01;
      else if (e == 8'hFF) e = 8'hFE;
      return {s, e, m};
   endfunction

   // True when v is a member of the IEEE-754 class cls
   function automatic bit class_ok(input int cls, input logic [31:0] v);
      logic [7:0]  e = v[30:23];
      logic [22:0] m = v[22:0];
      case (cls)
         0:       return (e == 8'h00) && (m == 23'h0);
         1:       return (e == 8'h00) && (m != 23'h0);
         3:       return (e == 8'hFF) && (m == 23'h0);
         4:       return (e == 8'hFF) && (m != 23'h0);
         default: return (e != 8'h00) && (e != 8'hFF);
      endcase
   endfunction

   task automatic model_reset();
      e_valid = 0; e_busy = 0; e_done = 0; e_sent = 0;
      e_A = 0; e_B = 0; m_num = 0; m_ca = 0; m_cb = 0;
      m_la = 32'hACE1_2468;
      m_lb = 32'hACE1_2468 ^ 32'h5A5A_5A5A;
   endtask

   // Advance the model by one clock using the inputs the DUT will sample next
   task automatic model_next();
      if (!e_busy) begin
         if (start) begin
            m_ca = int'(class_a); m_cb = int'(class_b); m_num = int'(num_pairs);
            e_sent = 0; e_busy = 1;
            if (m_num == 0) e_done = 1;
            else begin
               e_valid = 1;
               e_A = m_operand(m_ca, m_la);
               e_B = m_operand(m_cb, m_lb);
            end
         end
      end else if (e_done) begin
         e_busy = 0; e_done = 0;
      end else begin
         if (out_ready) begin
            m_la = m_step(m_la); m_lb = m_step(m_lb);
            e_sent++;
            if (e_sent == m_num) begin
               e_valid = 0; e_done = 1;
            end else begin
               e_A = m_operand(m_ca, m_la);
               e_B = m_operand(m_cb, m_lb);
            end
         end
         if (abort) begin
            e_valid = 0; e_busy = 0; e_done = 0;
         end
      end
   endtask

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("pairs_sent", 32'(pairs_sent), 32'(e_sent));
      if (e_valid) begin
         chk("number_A", number_A, e_A);
         chk("number_B", number_B, e_B);
      end
      if (rst_n && out_valid && out_ready) begin
         qa.push_back(number_A);
         qb.push_back(number_B);
         if (m_ca != 7) chk("class_A", 32'(class_ok(m_ca, number_A)), 32'd1);
         if (m_cb != 7) chk("class_B", 32'(class_ok(m_cb, number_B)), 32'd1);
      end
      if (rst_n) model_next();
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int ca, input int cb, input int n, input bit rnd, input int budget);
      bit fin = 0;
      class_a = 3'(ca); class_b = 3'(cb); num_pairs = 16'(n);
      start = 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < budget && !fin; i++) begin
         if (!busy) fin = 1;
         else begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
         end
      end
      if (!fin) chk("run_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_sent(input int n, input int budget);
      bit fin = 0;
      for (int i = 0; i < budget && !fin; i++) begin
         if (int'(pairs_sent) == n) fin = 1;
         else cyc();
      end
      if (!fin) chk("wait_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst_n = 0; start = 0; class_a = 0; class_b = 0; num_pairs = 0;
      out_ready = 0; abort = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_A", number_A, 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sent", 32'(pairs_sent), 32'd0);
      rst_n = 1;
      cyc();

      // zero class, three back-to-back pairs
      qa.delete(); qb.delete();
      run(0, 0, 3, 0, 20);
      chk("t1_sent", 32'(pairs_sent), 32'd3);
      chk("t1_count", 32'(qa.size()), 32'd3);
      if (qa.size() == 3) begin
         chk("t1_A0", qa[0], 32'h8000_0000);
         chk("t1_A1", qa[1], 32'h0000_0000);
         chk("t1_A2", qa[2], 32'h0000_0000);
         chk("t1_B0", qb[0], 32'h8000_0000);
         chk("t1_B1", qb[1], 32'h0000_0000);
         chk("t1_B2", qb[2], 32'h8000_0000);
      end

      // empty run
      run(0, 0, 0, 0, 10);
      chk("t2_sent", 32'(pairs_sent), 32'd0);

      // INF / NaN under random backpressure
      run(3, 4, 1000, 1, 20000);
      chk("t3_sent", 32'(pairs_sent), 32'd1000);

      // NORM / SUB, full rate
      run(2, 1, 10000, 0, 12000);
      chk("t4_sent", 32'(pairs_sent), 32'd10000);

      // reset mid-run, then restart from seed
      class_a = 0; class_b = 0; num_pairs = 16'd10; start = 1; out_ready = 1;
      cyc();
      start = 0;
      wait_sent(5, 50);
      rst_n = 0;
      #1;
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_A", number_A, 32'h0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_sent", 32'(pairs_sent), 32'd0);
      cyc();
      rst_n = 1;
      cyc();
      qa.delete(); qb.delete();
      run(7, 7, 1, 0, 20);
      chk("t5_count", 32'(qa.size()), 32'd1);
      if (qa.size() == 1) begin
         chk("t5_A0", qa[0], 32'hACE1_2468);
         chk("t5_B0", qb[0], 32'hF6BB_7E32);
      end

`ifdef FPA_GEN_ABORT_EN
      class_a = 2; class_b = 2; num_pairs = 16'd8; start = 1; out_ready = 1;
      cyc();
      start = 0;
      wait_sent(4, 50);
      out_ready = 0; abort = 1;
      cyc();
      abort = 0;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_sent", 32'(pairs_sent), 32'd4);
      run(2, 2, 2, 0, 20);
      chk("t6_rerun", 32'(pairs_sent), 32'd2);
`endif

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
